// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter/sequencer for a single-port memory.
//
// Port 0 (instruction fetch) and port 1 (load/store) each run req/ack
// transactions. Only one memory access is in flight at a time. The port that
// wins takes its we/addr/wdata into latches. The memory strobes are decoded
// from the state and those latches.
//
// Ports:
//   clk                   clock, all state on posedge
//   rst                   asynchronous, active-low reset
//   pN_req                request, held high until ack
//   pN_we                 1 = write, 0 = read (sampled at grant)
//   pN_addr [ADDR_W]      address (sampled at grant)
//   pN_wdata [DATA_W]     write data (sampled at grant)
//   pN_ack                one-cycle completion pulse
//   pN_rdata [DATA_W]     read data, valid with ack, held until the next read ack
//   pN_err                out-of-range flag, valid with ack only
//   mem_ce/r/w/oe         memory strobes
//   mem_addr, mem_wdata   memory address and write data
//   mem_rdata             memory read data
//   busy                  transaction in progress
//   gnt                   port that owns the current or last transaction
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int ADDR_LIMIT = 1025
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              mem_ce,
    output logic              mem_r,
    output logic              mem_w,
    output logic              mem_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, READ_OUT, DONE} state_t;

    localparam logic [ADDR_W:0] LIMIT_EXT = (ADDR_W+1)'(ADDR_LIMIT);

    state_t            state_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic in_range;
    logic sel_next;
    logic complete;

    assign in_range = ({1'b0, addr_reg} < LIMIT_EXT);

    // A lone requester wins. When both ports request, the port that did not
    // own the last transaction wins.
    assign sel_next = (p0_req && p1_req) ? ~gnt : p1_req;

    // The edge that moves the FSM into DONE is the same edge that raises the
    // ack. For a write this edge leaves ACCESS. For a read it leaves READ_OUT.
    assign complete = ((state_reg == ACCESS) && we_reg) || (state_reg == READ_OUT);

    // The strobes are decoded from state. An asynchronous reset therefore
    // drops them at once. An out-of-range access never enables the memory.
    assign mem_ce    = ((state_reg == ACCESS) || (state_reg == READ_OUT)) && in_range;
    assign mem_r     = (state_reg == ACCESS) && !we_reg && in_range;
    assign mem_w     = (state_reg == ACCESS) && we_reg && in_range;
    assign mem_oe    = (state_reg == READ_OUT) && in_range;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            gnt       <= 1'b1;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_err    <= 1'b0;
            p1_err    <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p0_err <= 1'b0;
            p1_err <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        gnt       <= sel_next;
                        we_reg    <= sel_next ? p1_we    : p0_we;
                        addr_reg  <= sel_next ? p1_addr  : p0_addr;
                        wdata_reg <= sel_next ? p1_wdata : p0_wdata;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    state_reg <= we_reg ? DONE : READ_OUT;
                end
                READ_OUT: begin
                    if (gnt) begin
                        p1_rdata <= in_range ? mem_rdata : '0;
                    end else begin
                        p0_rdata <= in_range ? mem_rdata : '0;
                    end
                    state_reg <= DONE;
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
            if (complete) begin
                if (gnt) begin
                    p1_ack <= 1'b1;
                    p1_err <= !in_range;
                end else begin
                    p0_ack <= 1'b1;
                    p0_err <= !in_range;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It includes a small synchronous memory, a
// transaction-level model that is checked every cycle, and directed
// scenarios with hand-computed expectations.
module tb_mem_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int LIMIT = 1025;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ack, p1_ack, p0_err, p1_err;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          mem_ce, mem_r, mem_w, mem_oe, busy, gnt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ADDR_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_ce(mem_ce), .mem_r(mem_r), .mem_w(mem_w), .mem_oe(mem_oe),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .gnt(gnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        else
            passes++;
    endtask

    // Single-port synchronous memory. A read captures data when mem_r is high,
    // and that data is on the output in the following cycle.
    logic [DW-1:0] dev_mem [0:LIMIT-1];
    logic [DW-1:0] dev_out = '0;
    always @(posedge clk) begin
        if (mem_ce && mem_w && mem_addr < LIMIT) dev_mem[mem_addr] <= mem_wdata;
        if (mem_ce && mem_r && mem_addr < LIMIT) dev_out <= dev_mem[mem_addr];
    end
    assign mem_rdata = dev_out;

    // Transaction-level model. A grant in cycle g gives strobes in cycle g+1.
    // A read also gets oe in g+2. The ack arrives in g+2 for a write and
    // g+3 for a read.
    logic [DW-1:0] model_mem [0:LIMIT-1];
    bit            m_act = 0;
    int            m_g;
    bit            m_port, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_gnt = 1;
    logic [DW-1:0] m_rdata [2];
    int            k, lat;
    bit            inr, e_ack, just_done, win;

    // Monitor state used by the directed checks.
    int last_w_cyc = -1, last_r_cyc = -1, last_oe_cyc = -1;
    int ce_cnt = 0, both_ack = 0;
    int ack_cnt [2];
    int ack_seq [$];

    initial begin
        for (int i = 0; i < LIMIT; i++) begin
            dev_mem[i]   = 8'(i) ^ 8'h5A;
            model_mem[i] = 8'(i) ^ 8'h5A;
        end
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        ack_cnt[0] = 0;
        ack_cnt[1] = 0;
    end

    always @(negedge clk) begin
        if (mem_w) last_w_cyc = cyc;
        if (mem_r) last_r_cyc = cyc;
        if (mem_oe) last_oe_cyc = cyc;
        if (mem_ce) ce_cnt++;
        if (p0_ack && p1_ack) both_ack++;
        if (p0_ack) begin
            ack_cnt[0]++;
            ack_seq.push_back(0);
            $display("txn cycle %0d port 0 rdata %02h err %0b", cyc, p0_rdata, p0_err);
        end
        if (p1_ack) begin
            ack_cnt[1]++;
            ack_seq.push_back(1);
            $display("txn cycle %0d port 1 rdata %02h err %0b", cyc, p1_rdata, p1_err);
        end

        if (!rst) begin
            m_act      = 0;
            m_gnt      = 1;
            m_rdata[0] = '0;
            m_rdata[1] = '0;
            chk("rst_ce", mem_ce, 0);
            chk("rst_r", mem_r, 0);
            chk("rst_w", mem_w, 0);
            chk("rst_oe", mem_oe, 0);
            chk("rst_busy", busy, 0);
            chk("rst_gnt", gnt, 1);
            chk("rst_acks", {p0_ack, p1_ack, p0_err, p1_err}, 0);
            chk("rst_rdata", {p0_rdata, p1_rdata}, 0);
        end else begin
            k         = m_act ? (cyc - m_g) : 0;
            lat       = m_we ? 2 : 3;
            inr       = m_addr < LIMIT;
            e_ack     = m_act && (k == lat);
            just_done = e_ack;
            if (m_act && k == 1 && m_we && inr) model_mem[m_addr] = m_wdata;
            if (e_ack && !m_we) m_rdata[m_port] = inr ? model_mem[m_addr] : '0;
            chk("mem_ce", mem_ce, m_act && inr && (k == 1 || (k == 2 && !m_we)));
            chk("mem_r", mem_r, m_act && inr && k == 1 && !m_we);
            chk("mem_w", mem_w, m_act && inr && k == 1 && m_we);
            chk("mem_oe", mem_oe, m_act && inr && k == 2 && !m_we);
            chk("busy", busy, m_act && k >= 1 && k <= lat);
            chk("gnt", gnt, m_gnt);
            chk("p0_ack", p0_ack, e_ack && m_port == 0);
            chk("p1_ack", p1_ack, e_ack && m_port == 1);
            chk("p0_err", p0_err, e_ack && m_port == 0 && !inr);
            chk("p1_err", p1_err, e_ack && m_port == 1 && !inr);
            chk("p0_rdata", p0_rdata, m_rdata[0]);
            chk("p1_rdata", p1_rdata, m_rdata[1]);
            if (mem_ce || (m_act && inr && k == 1)) chk("mem_addr", mem_addr, m_addr);
            if (m_act && inr && k == 1 && m_we) chk("mem_wdata", mem_wdata, m_wdata);
            if (just_done) m_act = 0;
            if (!m_act && !just_done && (p0_req || p1_req)) begin
                win     = (p0_req && p1_req) ? !m_gnt : p1_req;
                m_act   = 1;
                m_g     = cyc;
                m_port  = win;
                m_we    = win ? p1_we : p0_we;
                m_addr  = win ? p1_addr : p0_addr;
                m_wdata = win ? p1_wdata : p0_wdata;
                m_gnt   = win;
            end
        end
    end

    task automatic drive(input bit port, input bit req, input bit we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic wait_ack(input bit port, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? p1_ack : p0_ack) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("ack_timeout", 1, 0);
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    int start, at, c0, c1, ce0;

    initial begin
        repeat (3) next_drive();
        chk("reset_gnt", gnt, 1);
        chk("reset_busy", busy, 0);
        rst = 1;

        // p1 write 0x0010 <= 0xA5, then p0 read back.
        next_drive();
        start = cyc;
        drive(1, 1, 1, 16'h0010, 8'hA5);
        wait_ack(1, at);
        chk("t2_w_cycle", last_w_cyc - start, 1);
        chk("t2_ack_lat", at - start, 2);
        next_drive();
        drive(1, 0, 0, '0, '0);
        start = cyc;
        drive(0, 1, 0, 16'h0010, 8'h00);
        wait_ack(0, at);
        chk("t2_r_cycle", last_r_cyc - start, 1);
        chk("t2_oe_cycle", last_oe_cyc - start, 2);
        chk("t2_ack_lat", at - start, 3);
        chk("t2_rdata", p0_rdata, 8'hA5);
        next_drive();
        drive(0, 0, 0, '0, '0);

        // Both ports request together after reset and hold their requests.
        rst = 0;
        next_drive();
        rst = 1;
        ack_seq.delete();
        c0 = ack_cnt[0];
        c1 = ack_cnt[1];
        both_ack = 0;
        drive(0, 1, 1, 16'h0020, 8'h11);
        drive(1, 1, 1, 16'h0021, 8'h22);
        repeat (10) @(posedge clk);
        #1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        repeat (4) next_drive();
        chk("t3_p0_acks", ack_cnt[0] - c0, 2);
        chk("t3_p1_acks", ack_cnt[1] - c1, 2);
        chk("t3_both_ack", both_ack, 0);
        chk("t3_seq_len", ack_seq.size(), 4);
        for (int i = 0; i < 4 && i < ack_seq.size(); i++)
            chk("t3_order", ack_seq[i], i % 2);

        // Out-of-range read, then the last valid address.
        ce0 = ce_cnt;
        start = cyc;
        drive(0, 1, 0, 16'h0401, 8'h00);
        wait_ack(0, at);
        chk("t4_oor_lat", at - start, 3);
        chk("t4_oor_err", p0_err, 1);
        chk("t4_oor_rdata", p0_rdata, 0);
        chk("t4_oor_ce", ce_cnt - ce0, 0);
        next_drive();
        start = cyc;
        drive(0, 1, 0, 16'h0400, 8'h00);
        wait_ack(0, at);
        chk("t4_edge_err", p0_err, 0);
        chk("t4_edge_rdata", p0_rdata, 8'h5A);
        next_drive();
        drive(0, 0, 0, '0, '0);

        // Asynchronous reset during the read-out phase of a p0 read.
        drive(0, 1, 0, 16'h0010, 8'h00);
        c0 = ack_cnt[0];
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t5_pre_oe", mem_oe, 1);
        rst = 0;
        drive(0, 0, 0, '0, '0);
        #1;
        chk("t5_oe_drop", mem_oe, 0);
        chk("t5_ce_drop", mem_ce, 0);
        chk("t5_busy_drop", busy, 0);
        chk("t5_gnt", gnt, 1);
        next_drive();
        rst = 1;
        repeat (3) next_drive();
        chk("t5_no_ack", ack_cnt[0] - c0, 0);
        start = cyc;
        drive(1, 1, 0, 16'h0010, 8'h00);
        wait_ack(1, at);
        chk("t5_p1_lat", at - start, 3);
        chk("t5_p1_rdata", p1_rdata, 8'hA5);
        next_drive();
        drive(1, 0, 0, '0, '0);

        // p0 drops its request while the transaction is in ACCESS.
        start = cyc;
        c1 = ack_cnt[1];
        drive(0, 1, 0, 16'h0021, 8'h00);
        next_drive();
        drive(0, 0, 0, '0, '0);
        wait_ack(0, at);
        chk("t6_lat", at - start, 3);
        chk("t6_rdata", p0_rdata, 8'h22);
        repeat (3) next_drive();
        chk("t6_p1_quiet", ack_cnt[1] - c1, 0);
        chk("t6_p1_rdata", p1_rdata, 8'hA5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
